// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: fetch sequencer states, PC width and branch-type decode encodings.
package kgp_risc_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } pc_state_e;

  localparam int PC_W_DEF = 10;

  localparam logic [2:0] OPC_BRANCH = 3'b011;
  localparam logic [3:0] FC_CALL    = 4'd9;
  localparam logic [3:0] FC_RET     = 4'd10;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_n;

  // An empty pop yields 0 rather than stale contents.
  assign top = empty ? '0 : mem[wr_ptr - 1'b1];

  always_comb begin
    count_n = count;
    if (push) count_n = (count == FULL_CNT) ? count : count + 1'b1;
    else if (pop && count != '0) count_n = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (pop) begin
        if (count == '0) err <= 1'b1;
        else wr_ptr <= wr_ptr - 1'b1;
      end
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == FULL_CNT);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with redirect flush and return-address tracking.
// PC_SEQ_RAS_EN selects the full ras_stack; otherwise a single legacy return register is used.
module pc_sequencer
  import kgp_risc_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] br_pc,
  input  logic            br_call,
  input  logic            br_ret,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  // state    | meaning
  // BOOT     | out of reset, pc=0 not yet valid
  // RUN      | live fetch, pc advances unless stalled
  // REDIRECT | wrong-path squash, pc parked on target
  // HALTED   | fetch stopped until reset

  pc_state_e       state;
  logic [2:0]      flush_cnt;
  logic            redirect_req;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] redirect_pc;

  // Redirects only come from RUN; in REDIRECT br_valid belongs to a squashed slot.
  assign redirect_req = (state == RUN) && !halt && br_valid && br_taken;
  assign push         = redirect_req && br_call;
  assign pop          = redirect_req && br_ret && !br_call;
  assign ret_addr     = br_pc + 1'b1;
  assign redirect_pc  = pop ? ras_top : br_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= '0;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      flush_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (halt) begin
            state    <= HALTED;
            pc_valid <= 1'b0;
          end else if (redirect_req) begin
            state     <= REDIRECT;
            pc        <= redirect_pc;
            pc_valid  <= 1'b0;
            flush     <= 1'b1;
            flush_cnt <= 3'(FLUSH_CYCLES);
          end else if (!stall) begin
            pc <= pc + 1'b1;
          end
        end
        REDIRECT: begin
          if (halt) begin
            state <= HALTED;
            flush <= 1'b0;
          end else if (flush_cnt == 3'd1) begin
            state    <= RUN;
            flush    <= 1'b0;
            pc_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          pc_valid <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_RAS_EN
  ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .err       (ras_err)
  );
`else
  logic [PC_W-1:0] ra;
  logic            ra_valid;
  logic            ra_err;

  // Legacy ra: returns read without clearing, so ra stays valid once written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra       <= '0;
      ra_valid <= 1'b0;
      ra_err   <= 1'b0;
    end else begin
      if (push) begin
        ra       <= ret_addr;
        ra_valid <= 1'b1;
      end
      if (pop && !ra_valid) ra_err <= 1'b1;
    end
  end

  assign ras_top   = ra;
  assign ras_empty = !ra_valid;
  assign ras_full  = ra_valid;
  assign ras_err   = ra_err;
`endif

endmodule
